// File: rtl/tt_um_devmonkza_uart_tx.sv
// Byte-wide UART transmitter tile (8N1, LSB first).
// A synchronised rising edge on uio_in[0] latches ui_in and sends one frame
// on uio_out[1]. uio_out[2] is busy. uo_out holds the mod-256 sum of every
// completed frame.
// Optional build macro: UART_TX_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit, giving an 11-bit frame.
module tt_um_devmonkza_uart_tx #(
  parameter int unsigned BAUD_DIV = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;
`endif

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  // request synchroniser and edge-detect flops
  logic sync1_q;
  logic sync2_q;
  logic sync3_q;
  logic req_rise;

  // transmitter state
  state_t      state_q, state_d;
  logic [15:0] baud_q,  baud_d;
  logic [2:0]  bit_q,   bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q,  data_d;
  logic [7:0]  sum_q,   sum_d;
  logic        tx_q,    tx_d;
  logic        busy_q,  busy_d;
  logic        baud_end;

  // ena and the spare request bits carry no function in this tile
  logic unused_inputs;
  assign unused_inputs = ^{ena, uio_in[7:1]};

  // two-flop synchroniser followed by a history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= uio_in[0];
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign req_rise = sync2_q & ~sync3_q;
  assign baud_end = (baud_q == BAUD_LAST);

  // next-state logic; tx is computed one cycle ahead so the pin is a flop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    sum_d   = sum_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        bit_d  = '0;
        if (req_rise) begin
          shreg_d = ui_in;
          data_d  = ui_in;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = ^data_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          sum_d   = sum_q + data_q;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state register; reset forces the line idle and abandons any frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign uo_out  = sum_q;
  assign uio_out = {5'b0_0000, busy_q, tx_q, 1'b0};
  assign uio_oe  = 8'b0000_0110;

endmodule
